// File: rtl/shiftout_arbiter.sv
// Shares one serial shift-out chain between NREQ requesters. Words are spaced so the shifter always finishes.
// Round-robin by default; define SHIFTOUT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module shiftout_arbiter #(
  parameter int NREQ        = 4,
  parameter int WIDTH       = 16,
  parameter int WAIT_CYCLES = 40
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NREQ-1:0]         req_i,
  input  logic [NREQ*WIDTH-1:0]   data_i,
  output logic [NREQ-1:0]         ack_o,
  output logic [WIDTH-1:0]        data_o,
  output logic                    data_rdy_o,
  output logic [$clog2(NREQ)-1:0] grant_o,
  output logic                    busy_o
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [NREQ-1:0]  ack_reg, ack_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic             rdy_reg, rdy_next;
  logic [GW-1:0]    grant_reg, grant_next;

  logic [WIDTH-1:0] word [NREQ];
  logic             win_valid;
  logic [GW-1:0]    win_idx;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign word[gi] = data_i[gi*WIDTH +: WIDTH];
  end

`ifdef SHIFTOUT_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest requesting index is the last one written.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        win_valid = 1'b1;
        win_idx   = GW'(i);
      end
    end
  end
`else
  // Offsets scanned from farthest to nearest so the first set bit after the last grant wins.
  always_comb begin
    int idx;
    win_valid = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int i = NREQ; i >= 1; i--) begin
      idx = (int'(grant_reg) + i) % NREQ;
      if (req_i[idx]) begin
        win_valid = 1'b1;
        win_idx   = GW'(idx);
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      ack_reg   <= '0;
      data_reg  <= '0;
      rdy_reg   <= 1'b0;
      grant_reg <= GW'(NREQ - 1);
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ack_reg   <= ack_next;
      data_reg  <= data_next;
      rdy_reg   <= rdy_next;
      grant_reg <= grant_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (win_valid) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (cnt_reg == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_next   = cnt_reg;
    ack_next   = ack_reg;
    data_next  = data_reg;
    rdy_next   = rdy_reg;
    grant_next = grant_reg;
    case (state_reg)
      S_IDLE: begin
        if (win_valid) begin
          ack_next   = NREQ'(1) << win_idx;
          data_next  = word[win_idx];
          grant_next = win_idx;
        end
      end
      S_ISSUE: begin
        rdy_next = 1'b1;
        ack_next = '0;
        cnt_next = CW'(WAIT_CYCLES - 1);
      end
      S_WAIT: begin
        rdy_next = 1'b0;
        if (cnt_reg != '0) cnt_next = cnt_reg - CW'(1);
      end
      // Recover from a corrupted state as if reset, but keep the last word on the shifter input.
      default: begin
        cnt_next   = '0;
        ack_next   = '0;
        rdy_next   = 1'b0;
        grant_next = GW'(NREQ - 1);
      end
    endcase
  end

  assign ack_o      = ack_reg;
  assign data_o     = data_reg;
  assign data_rdy_o = rdy_reg;
  assign grant_o    = grant_reg;
  assign busy_o     = (state_reg == S_ISSUE) || (state_reg == S_WAIT);

endmodule

// File: tb/tb_shiftout_arbiter.sv
// Scoreboard bench for shiftout_arbiter with a behavioural 16-bit shifter+latch on its output.
module tb_shiftout_arbiter;

  localparam int NREQ        = 4;
  localparam int WIDTH       = 16;
  localparam int WAIT_CYCLES = 40;
  localparam int SPACING     = 42;
  localparam int SH_BUSY     = 2 * WIDTH + 3;

  logic                  clk_i   = 1'b0;
  logic                  reset_i = 1'b1;
  logic [NREQ-1:0]       req_i   = '0;
  logic [NREQ*WIDTH-1:0] data_i  = '0;
  logic [NREQ-1:0]       ack_o;
  logic [WIDTH-1:0]      data_o;
  logic                  data_rdy_o;
  logic [1:0]            grant_o;
  logic                  busy_o;

  shiftout_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_i(req_i), .data_i(data_i),
    .ack_o(ack_o), .data_o(data_o), .data_rdy_o(data_rdy_o),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          idx;
    logic [15:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] latch_q[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, ack_cnt = 0, strobe_cnt = 0, latched_cnt = 0;
  int last_ack_cyc = 0;
  bit have_last = 0, spacing_chk = 0;
  int rdy_phase = 0;

`ifdef SHIFTOUT_ARB_FIXED_PRIO_EN
  int order[5] = '{0, 0, 0, 0, 0};
`else
  int order[5] = '{0, 1, 2, 3, 0};
`endif
  logic [15:0] words[4] = '{16'h1111, 16'h2D2D, 16'h3C5A, 16'h4E71};

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("[TB] ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Ack monitor: pops the scoreboard on every ack and checks the strobe that must follow.
  always @(negedge clk_i) begin
    if (reset_i) begin
      rdy_phase = 0;
      have_last = 0;
    end else begin
      if (rdy_phase == 1) begin
        check("strobe_on", 32'(data_rdy_o), 1);
        rdy_phase = 2;
      end else if (rdy_phase == 2) begin
        check("strobe_off", 32'(data_rdy_o), 0);
        rdy_phase = 0;
      end
      if (data_rdy_o) strobe_cnt++;
      if (ack_o != '0) begin
        ack_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(ack_o), 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("ack_onehot", 32'(ack_o), 32'(1) << e.idx);
          check("ack_data", 32'(data_o), 32'(e.word));
          check("ack_grant", 32'(grant_o), 32'(e.idx));
          check("ack_busy", 32'(busy_o), 1);
          latch_q.push_back(e.word);
        end
        if (spacing_chk && have_last) check("grant_spacing", 32'(cyc - last_ack_cyc), SPACING);
        last_ack_cyc = cyc;
        have_last    = 1;
        rdy_phase    = 1;
      end
    end
  end

  // Shifter model: rising strobe loads, LSB first, one bit per two cycles, latch pulse at the end.
  logic [15:0] sh_reg = '0, rx = '0;
  int  sh_cnt = 0;
  bit  prev_rdy = 0;
  always @(negedge clk_i) begin
    if (reset_i) begin
      sh_cnt   = 0;
      prev_rdy = 0;
      latch_q.delete();
    end else begin
      if (data_rdy_o && !prev_rdy) begin
        check("shifter_free_at_strobe", 32'(sh_cnt), 0);
        sh_reg = data_o;
        rx     = '0;
        sh_cnt = SH_BUSY;
      end else if (sh_cnt > 0) begin
        sh_cnt--;
        if (sh_cnt >= 3 && (sh_cnt % 2) == 1) begin
          rx     = {sh_reg[0], rx[15:1]};
          sh_reg = sh_reg >> 1;
        end
        if (sh_cnt == 1) begin
          latched_cnt++;
          check("latch_expected", 32'(latch_q.size() != 0), 1);
          if (latch_q.size() != 0) check("latch_word", 32'(rx), 32'(latch_q.pop_front()));
        end
      end
      prev_rdy = data_rdy_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic set_word(input int k, input logic [15:0] w);
    data_i[k*WIDTH +: WIDTH] = w;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(2);
    reset_i = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_ack_seen"}, 32'(ack_cnt >= target), 1);
  endtask

  initial begin
    int s0, a0;
    exp_t e;

    // 1: reset values, then a single word
    reset_i = 1'b1;
    tick(2);
    check("rst_data", 32'(data_o), 0);
    check("rst_rdy", 32'(data_rdy_o), 0);
    check("rst_ack", 32'(ack_o), 0);
    check("rst_grant", 32'(grant_o), 3);
    check("rst_busy", 32'(busy_o), 0);
    reset_i = 1'b0;
    set_word(0, 16'hA5C3);
    e.idx = 0; e.word = 16'hA5C3; exp_q.push_back(e);
    req_i = 4'b0001;
    wait_acks(1, 10, "t1");
    req_i = 4'b0000;
    tick(60);

    // 2/6: all requesting, back-to-back words through the shifter
    do_reset();
    for (int k = 0; k < 4; k++) set_word(k, words[k]);
    for (int i = 0; i < 5; i++) begin
      e.idx = order[i]; e.word = words[order[i]]; exp_q.push_back(e);
    end
    spacing_chk = 1;
    req_i = 4'b1111;
    wait_acks(6, 5 * SPACING + 20, "t2");
    e.idx = 1; e.word = words[1]; exp_q.push_back(e);
    req_i = 4'b1110;
    wait_acks(7, SPACING + 10, "t2_after_drop");
    req_i = 4'b0000;
    spacing_chk = 0;
    tick(60);

    // 4: request rising and falling inside WAIT is ignored
    do_reset();
    s0 = strobe_cnt;
    set_word(0, 16'h0F0F);
    set_word(2, 16'hDEAD);
    e.idx = 0; e.word = 16'h0F0F; exp_q.push_back(e);
    req_i = 4'b0001;
    wait_acks(8, 10, "t4");
    req_i = 4'b0000;
    a0 = ack_cnt;
    tick(10);
    req_i = 4'b0100;
    tick(10);
    req_i = 4'b0000;
    tick(60);
    check("t4_no_extra_ack", 32'(ack_cnt - a0), 0);
    check("t4_one_strobe", 32'(strobe_cnt - s0), 1);
    check("t4_idle", 32'(busy_o), 0);

    // 5: reset mid-WAIT with counter at 20, pending request granted right after release
    do_reset();
    set_word(1, 16'h1234);
    set_word(3, 16'hBEEF);
    e.idx = 1; e.word = 16'h1234; exp_q.push_back(e);
    req_i = 4'b0010;
    wait_acks(9, 10, "t5");
    req_i = 4'b0000;
    tick(19);
    req_i   = 4'b1000;
    reset_i = 1'b1;
    tick(1);
    check("t5_busy", 32'(busy_o), 0);
    check("t5_rdy", 32'(data_rdy_o), 0);
    check("t5_grant", 32'(grant_o), 3);
    check("t5_ack", 32'(ack_o), 0);
    reset_i = 1'b0;
    e.idx = 3; e.word = 16'hBEEF; exp_q.push_back(e);
    tick(1);
    check("t5_first_idle_grant", 32'(ack_o), 32'h8);
    req_i = 4'b0000;
    tick(60);

    check("end_exp_q_empty", 32'(exp_q.size()), 0);
    check("end_latch_q_empty", 32'(latch_q.size()), 0);
    check("end_ack_total", 32'(ack_cnt), 10);
    check("end_latched_total", 32'(latched_cnt), 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
